transmissao_quadro_serial: RTL and testbench

Parametrised successor to the pixel-transmission control unit. It integrates the control FSM, row/column counters, byte sequencing and a byte-select mux. It walks a LINHAS x COLUNAS pixel memory row-major and sends each pixel as BYTES_POR_PIXEL bytes through the serial TX handshake, with an optional header byte, an optional XOR checksum trailer and an abort input. It sits between the pixel memory and the serial_tx core.

---
 rtl/transmissao_pkg.sv | 30 +++
 rtl/contador_m.sv | 39 +++
 rtl/transmissao_quadro_serial.sv | 166 ++++++++++++++++
 tb/tb_transmissao_quadro_serial.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transmissao_pkg.sv
// Shared state encoding and helpers for the serial frame transmitter.
// The enum values double as the db_estado debug codes.
package transmissao_pkg;

   typedef enum logic [3:0] {
      Inicial     = 4'd0,
      Preparacao  = 4'd1,
      CarregaCab  = 4'd2,
      PartidaCab  = 4'd3,
      EsperaCab   = 4'd4,
      Carrega     = 4'd5,
      Partida     = 4'd6,
      Espera      = 4'd7,
      AvancaByte  = 4'd8,
      AvancaPixel = 4'd9,
      EsperaEnd   = 4'd10,
      CarregaChk  = 4'd11,
      PartidaChk  = 4'd12,
      EsperaChk   = 4'd13,
      Fim         = 4'd14
   } estado_e;

   localparam logic [3:0] DB_ILEGAL = 4'hF;

   // Address width for a counter of n positions, never below one bit.
   function automatic int unsigned largura_end(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter: synchronous clear, count enable, terminal-value flag.
// With M=1 the value is stuck at 0 and fim is always high.
module contador_m
   import transmissao_pkg::*;
#(
   parameter int unsigned M = 3,
   localparam int unsigned W = largura_end(M)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   output logic [W-1:0] valor,
   output logic         fim
);

   logic [W-1:0] valor_q, valor_d;

   assign fim   = (valor_q == W'(M - 1));
   assign valor = valor_q;

   always_comb begin
      valor_d = valor_q;
      if (zera) begin
         valor_d = '0;
      end else if (conta) begin
         valor_d = fim ? '0 : valor_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valor_q <= '0;
      end else begin
         valor_q <= valor_d;
      end
   end

endmodule

// File: rtl/transmissao_quadro_serial.sv
// Walks a LINHAS x COLUNAS pixel memory row-major and streams every pixel, MSB byte
// first, through the serial_tx start/done handshake, with optional header and XOR trailer.
module transmissao_quadro_serial
   import transmissao_pkg::*;
#(
   parameter int unsigned LINHAS          = 3,
   parameter int unsigned COLUNAS         = 3,
   parameter int unsigned BYTES_POR_PIXEL = 2,
   parameter bit          HEADER_EN       = 1'b1,
   parameter logic [7:0]  CABECALHO       = 8'hAA,
   parameter bit          CHECKSUM_EN     = 1'b1
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               iniciar,
   input  logic                               abortar,
   input  logic [8*BYTES_POR_PIXEL-1:0]       dado_pixel,
   input  logic                               pronto_serial,
   output logic                               partida_serial,
   output logic [7:0]                         dado_serial,
   output logic [largura_end(LINHAS)-1:0]     endereco_linha,
   output logic [largura_end(COLUNAS)-1:0]    endereco_coluna,
   output logic                               ocupado,
   output logic                               fim_transmissao,
   output logic [3:0]                         db_estado
);

   estado_e    estado_q, estado_d;
   logic [7:0] dado_q, dado_d;
   logic [7:0] chk_q, chk_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] byte_sel;
   logic [3:0] codigo;
   logic       zera, conta_col, conta_lin;
   logic       fim_col, fim_lin;
   logic       ultimo_byte;

   contador_m #(.M(LINHAS)) u_linha (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta_lin),
      .valor (endereco_linha),
      .fim   (fim_lin)
   );

   contador_m #(.M(COLUNAS)) u_coluna (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta_col),
      .valor (endereco_coluna),
      .fim   (fim_col)
   );

   // Byte index 0 selects the most significant byte of the pixel word.
   always_comb begin
      byte_sel = '0;
      for (int i = 0; i < BYTES_POR_PIXEL; i++) begin
         if (idx_q == 2'(BYTES_POR_PIXEL - 1 - i)) begin
            byte_sel = dado_pixel[8*i +: 8];
         end
      end
   end

   assign ultimo_byte = (idx_q == 2'(BYTES_POR_PIXEL - 1));

   always_comb begin
      estado_d  = estado_q;
      dado_d    = dado_q;
      chk_d     = chk_q;
      idx_d     = idx_q;
      zera      = 1'b0;
      conta_col = 1'b0;
      conta_lin = 1'b0;

      case (estado_q)
         Inicial: begin
            if (iniciar) estado_d = Preparacao;
         end
         Preparacao: begin
            zera     = 1'b1;
            idx_d    = '0;
            chk_d    = '0;
            estado_d = HEADER_EN ? CarregaCab : Carrega;
         end
         CarregaCab: begin
            dado_d   = CABECALHO;
            estado_d = PartidaCab;
         end
         PartidaCab: estado_d = EsperaCab;
         EsperaCab: begin
            if (pronto_serial) estado_d = Carrega;
         end
         Carrega: begin
            dado_d   = byte_sel;
            chk_d    = chk_q ^ byte_sel;
            estado_d = Partida;
         end
         Partida: estado_d = Espera;
         Espera: begin
            if (pronto_serial) estado_d = ultimo_byte ? AvancaPixel : AvancaByte;
         end
         AvancaByte: begin
            idx_d    = idx_q + 2'd1;
            estado_d = Carrega;
         end
         AvancaPixel: begin
            idx_d     = '0;
            conta_col = 1'b1;
            // The row stays on the last line after the final pixel; FIM clears it.
            conta_lin = fim_col & ~fim_lin;
            if (fim_col && fim_lin) begin
               estado_d = CHECKSUM_EN ? CarregaChk : Fim;
            end else begin
               estado_d = EsperaEnd;
            end
         end
         EsperaEnd: estado_d = Carrega;
         CarregaChk: begin
            dado_d   = chk_q;
            estado_d = PartidaChk;
         end
         PartidaChk: estado_d = EsperaChk;
         EsperaChk: begin
            if (pronto_serial) estado_d = Fim;
         end
         Fim: begin
            zera     = 1'b1;
            idx_d    = '0;
            estado_d = Inicial;
         end
         default: estado_d = Inicial;
      endcase

      if (abortar) begin
         zera     = 1'b1;
         idx_d    = '0;
         chk_d    = '0;
         estado_d = Inicial;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= Inicial;
         dado_q   <= '0;
         chk_q    <= '0;
         idx_q    <= '0;
      end else begin
         estado_q <= estado_d;
         dado_q   <= dado_d;
         chk_q    <= chk_d;
         idx_q    <= idx_d;
      end
   end

   assign codigo          = estado_q;
   assign dado_serial     = dado_q;
   assign partida_serial  = (estado_q == PartidaCab) || (estado_q == Partida) ||
                            (estado_q == PartidaChk);
   assign fim_transmissao = (estado_q == Fim);
   assign ocupado         = (estado_q != Inicial);
   assign db_estado       = (codigo == DB_ILEGAL) ? DB_ILEGAL : codigo;

endmodule

// File: tb/tb_transmissao_quadro_serial.sv
// Directed-plus-random bench: a second instance covers the minimal 1x1x1 configuration.
module tb_transmissao_quadro_serial;

   localparam int unsigned L = 2;
   localparam int unsigned C = 3;
   localparam int unsigned B = 2;

   logic        clock = 1'b0;
   logic        reset, iniciar, abortar;
   logic [15:0] dado_pixel;
   logic        pronto_serial, pronto_resp, pronto_man;
   logic        partida_serial, ocupado, fim_transmissao;
   logic [7:0]  dado_serial;
   logic [0:0]  endereco_linha;
   logic [1:0]  endereco_coluna;
   logic [3:0]  db_estado;

   logic        iniciar_b, pronto_b, partida_b, ocupado_b, fim_b;
   logic [7:0]  dado_b;
   logic [0:0]  lin_b, col_b;
   logic [3:0]  db_b;

   logic [15:0] mem [L][C];
   logic [7:0]  cap_q[$];
   logic [7:0]  exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_fim = 0;
   int          pend = 0;
   int          atraso = 5;
   bit          resp_en = 1'b1;

   always #5 clock = ~clock;

   assign pronto_serial = pronto_resp | pronto_man;

   // Synchronous pixel memory: one cycle of read latency.
   always @(posedge clock) dado_pixel <= mem[endereco_linha][endereco_coluna];

   transmissao_quadro_serial #(
      .LINHAS(L), .COLUNAS(C), .BYTES_POR_PIXEL(B),
      .HEADER_EN(1'b1), .CABECALHO(8'hAA), .CHECKSUM_EN(1'b1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .iniciar         (iniciar),
      .abortar         (abortar),
      .dado_pixel      (dado_pixel),
      .pronto_serial   (pronto_serial),
      .partida_serial  (partida_serial),
      .dado_serial     (dado_serial),
      .endereco_linha  (endereco_linha),
      .endereco_coluna (endereco_coluna),
      .ocupado         (ocupado),
      .fim_transmissao (fim_transmissao),
      .db_estado       (db_estado)
   );

   transmissao_quadro_serial #(
      .LINHAS(1), .COLUNAS(1), .BYTES_POR_PIXEL(1),
      .HEADER_EN(1'b0), .CABECALHO(8'hAA), .CHECKSUM_EN(1'b0)
   ) dut_b (
      .clock           (clock),
      .reset           (reset),
      .iniciar         (iniciar_b),
      .abortar         (1'b0),
      .dado_pixel      (8'h5C),
      .pronto_serial   (pronto_b),
      .partida_serial  (partida_b),
      .dado_serial     (dado_b),
      .endereco_linha  (lin_b),
      .endereco_coluna (col_b),
      .ocupado         (ocupado_b),
      .fim_transmissao (fim_b),
      .db_estado       (db_b)
   );

   // Serial-side responder: records every started byte, answers pronto after 'atraso' cycles.
   initial begin
      pronto_resp = 1'b0;
      forever begin
         @(negedge clock);
         pronto_resp = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) pronto_resp = 1'b1;
         end
         if (partida_serial) begin
            cap_q.push_back(dado_serial);
            if (resp_en) pend = atraso;
         end
         if (fim_transmissao) n_fim++;
      end
   end

   task automatic ciclo();
      @(negedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference frame: header, each pixel MSB byte first in row-major order, XOR trailer.
   task automatic monta_esperado();
      logic [7:0] x;
      logic [7:0] byt;
      x = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hAA);
      for (int r = 0; r < L; r++) begin
         for (int c = 0; c < C; c++) begin
            for (int b = B - 1; b >= 0; b--) begin
               byt = mem[r][c][8*b +: 8];
               exp_q.push_back(byt);
               x = x ^ byt;
            end
         end
      end
      exp_q.push_back(x);
   endtask

   task automatic mem_rc();
      for (int r = 0; r < L; r++)
         for (int c = 0; c < C; c++) mem[r][c] = {8'(r), 8'(c)};
   endtask

   task automatic mem_aleat();
      for (int r = 0; r < L; r++)
         for (int c = 0; c < C; c++) mem[r][c] = 16'($urandom);
   endtask

   task automatic espera_fim(input string tag);
      bit achou;
      achou = 1'b0;
      for (int k = 0; k < 600 && !achou; k++) begin
         ciclo();
         if (fim_transmissao) achou = 1'b1;
      end
      check(tag, 32'(achou), 32'd1);
   endtask

   task automatic compara(input string tag, input int base);
      check({tag, "_len"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < cap_q.size()) check(tag, 32'(cap_q[base+i]), 32'(exp_q[i]));
      end
   endtask

   task automatic dispara();
      iniciar = 1'b1;
      ciclo();
      iniciar = 1'b0;
   endtask

   task automatic quadro(input string tag);
      int fim0;
      cap_q.delete();
      monta_esperado();
      fim0 = n_fim;
      dispara();
      espera_fim({tag, "_fim"});
      ciclo();
      check({tag, "_ocupado_cai"}, 32'(ocupado), 32'd0);
      check({tag, "_um_fim"}, 32'(n_fim - fim0), 32'd1);
      compara(tag, 0);
   endtask

   initial begin
      int seq_b [8] = '{0, 1, 5, 6, 7, 9, 14, 0};
      int n_part_b;
      int fim0;
      int n1;

      reset      = 1'b0;
      iniciar    = 1'b0;
      abortar    = 1'b0;
      pronto_man = 1'b0;
      iniciar_b  = 1'b0;
      pronto_b   = 1'b0;
      mem_rc();
      ciclo();
      check("rst_db", 32'(db_estado), 32'd0);
      check("rst_ocupado", 32'(ocupado), 32'd0);
      check("rst_partida", 32'(partida_serial), 32'd0);
      check("rst_dado", 32'(dado_serial), 32'd0);
      check("rst_end", 32'({endereco_linha, endereco_coluna}), 32'd0);
      check("rst_fim", 32'(fim_transmissao), 32'd0);
      ciclo();
      reset = 1'b1;
      ciclo();

      // Minimal configuration: one single-byte pixel, no header, no trailer.
      n_part_b = 0;
      for (int k = 0; k < 8; k++) begin
         check("seq_b", 32'(db_b), 32'(seq_b[k]));
         if (partida_b) begin
            n_part_b++;
            check("dado_b", 32'(dado_b), 32'h5C);
         end
         if (k == 6) check("fim_b", 32'(fim_b), 32'd1);
         iniciar_b = (k == 0);
         pronto_b  = (db_b == 4'd7);
         ciclo();
      end
      check("partidas_b", 32'(n_part_b), 32'd1);

      atraso = 5;
      quadro("quadro_rc");

      for (int f = 0; f < 2; f++) begin
         mem_aleat();
         atraso = int'($urandom_range(1, 6));
         quadro("quadro_aleat");
      end

      // Abort during the wait of the 4th byte.
      mem_rc();
      atraso = 5;
      cap_q.delete();
      fim0 = n_fim;
      dispara();
      for (int k = 0; k < 300 && cap_q.size() < 4; k++) ciclo();
      check("abort_4bytes", 32'(cap_q.size()), 32'd4);
      ciclo();
      check("abort_em_espera", 32'(db_estado), 32'd7);
      abortar = 1'b1;
      ciclo();
      abortar = 1'b0;
      check("abort_db", 32'(db_estado), 32'd0);
      check("abort_ocupado", 32'(ocupado), 32'd0);
      check("abort_end", 32'({endereco_linha, endereco_coluna}), 32'd0);
      repeat (10) ciclo();
      check("abort_sem_partida", 32'(cap_q.size()), 32'd4);
      check("abort_sem_fim", 32'(n_fim - fim0), 32'd0);
      check("abort_ocioso", 32'(db_estado), 32'd0);
      quadro("reenvio");

      // Stray pronto pulses outside the wait states.
      pronto_man = 1'b1;
      ciclo();
      pronto_man = 1'b0;
      check("pronto_inicial", 32'(db_estado), 32'd0);
      resp_en = 1'b0;
      cap_q.delete();
      monta_esperado();
      dispara();
      for (int k = 0; k < 20 && db_estado != 4'd4; k++) ciclo();
      repeat (3) ciclo();
      check("espera_sem_pronto", 32'(db_estado), 32'd4);
      pronto_man = 1'b1;
      ciclo();
      check("avanco_cab", 32'(db_estado), 32'd5);
      ciclo();
      pronto_man = 1'b0;
      check("pronto_carrega", 32'(db_estado), 32'd6);
      ciclo();
      check("espera_byte", 32'(db_estado), 32'd7);
      repeat (3) ciclo();
      check("um_avanco", 32'(db_estado), 32'd7);
      check("um_avanco_bytes", 32'(cap_q.size()), 32'd2);
      resp_en    = 1'b1;
      pronto_man = 1'b1;
      ciclo();
      pronto_man = 1'b0;
      espera_fim("manual_fim");
      ciclo();
      compara("quadro_manual", 0);

      // Back-to-back frames with iniciar held high.
      mem_aleat();
      atraso = 3;
      cap_q.delete();
      monta_esperado();
      fim0 = n_fim;
      iniciar = 1'b1;
      espera_fim("b2b_fim1");
      n1 = cap_q.size();
      ciclo();
      check("b2b_inicial", 32'(db_estado), 32'd0);
      ciclo();
      check("b2b_preparacao", 32'(db_estado), 32'd1);
      iniciar = 1'b0;
      espera_fim("b2b_fim2");
      ciclo();
      check("b2b_dois_fim", 32'(n_fim - fim0), 32'd2);
      check("b2b_n1", 32'(n1), 32'(exp_q.size()));
      compara("b2b_q2", n1);
      for (int i = 0; i < n1 && i < exp_q.size(); i++) check("b2b_q1", 32'(cap_q[i]), 32'(exp_q[i]));

      // Asynchronous reset mid-frame, between clock edges.
      mem_rc();
      atraso = 5;
      cap_q.delete();
      dispara();
      for (int k = 0; k < 300 && cap_q.size() < 5; k++) ciclo();
      ciclo();
      check("pre_rst_dado", 32'(dado_serial), 32'h01);
      #2;
      reset = 1'b0;
      #1;
      check("arst_db", 32'(db_estado), 32'd0);
      check("arst_ocupado", 32'(ocupado), 32'd0);
      check("arst_partida", 32'(partida_serial), 32'd0);
      check("arst_dado", 32'(dado_serial), 32'd0);
      check("arst_end", 32'({endereco_linha, endereco_coluna}), 32'd0);
      check("arst_fim", 32'(fim_transmissao), 32'd0);
      ciclo();
      ciclo();
      reset = 1'b1;
      cap_q.delete();
      repeat (10) ciclo();
      check("pos_rst_ocioso", 32'(db_estado), 32'd0);
      check("pos_rst_sem_partida", 32'(cap_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
